// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: recovers start/7-bit/stop frames from an asynchronous line,
// corrects single-bit errors and holds the decoded nibble on a valid/ready output.
module hamming74_serial_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] corrected_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] overrun_cnt
);

    // state | meaning
    // IDLE  | line idle, waiting for a falling edge (or for the line to recover after a bad stop)
    // START | timing to mid start bit to reject glitches
    // DATA  | sampling the seven codeword bits, cw[0] first
    // STOP  | sampling the stop bit
    // DONE  | decode and hand the word to the output register
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_BIT  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2);

    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [6:0]       cw_q, cw_d;
    logic             brk_q, brk_d;
    logic [3:0]       out_data_q, out_data_d;
    logic [2:0]       out_syn_q, out_syn_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] ferr_q, ferr_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;

    logic [2:0]       syn;
    logic [6:0]       cw_fix;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        syn    = {^(cw_q & 7'b1111000), ^(cw_q & 7'b1100110), ^(cw_q & 7'b1010101)};
        cw_fix = cw_q;
        if (syn != 3'd0) begin
            cw_fix = cw_q ^ (7'b0000001 << (syn - 3'd1));
        end
    end

    always_comb begin
        sync1_d     = rx;
        rx_s_d      = sync1_q;
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        cw_d        = cw_q;
        brk_d       = brk_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_valid_d = out_valid_q;
        corr_d      = corr_q;
        ferr_d      = ferr_q;
        ovr_d       = ovr_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (brk_q) begin
                    if (rx_s_q) begin
                        brk_d = 1'b0;
                    end
                end else if (!rx_s_q) begin
                    state_d = S_START;
                    timer_d = TMR_HALF;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        timer_d   = TMR_BIT;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    cw_d[bit_idx_q] = rx_s_q;
                    timer_d         = TMR_BIT;
                    if (bit_idx_q == 3'd6) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    if (rx_s_q) begin
                        state_d = S_DONE;
                    end else begin
                        // a held-low line must return high before the next start counts
                        state_d = S_IDLE;
                        brk_d   = 1'b1;
                        ferr_d  = sat_inc(ferr_q);
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!out_valid_q || out_ready) begin
                    out_data_d  = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
                    out_syn_d   = syn;
                    out_valid_d = 1'b1;
                    if (syn != 3'd0) begin
                        corr_d = sat_inc(corr_q);
                    end
                end else begin
                    ovr_d = sat_inc(ovr_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            cw_q        <= 7'd0;
            brk_q       <= 1'b0;
            out_data_q  <= 4'd0;
            out_syn_q   <= 3'd0;
            out_valid_q <= 1'b0;
            corr_q      <= '0;
            ferr_q      <= '0;
            ovr_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            cw_q        <= cw_d;
            brk_q       <= brk_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_valid_q <= out_valid_d;
            corr_q      <= corr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_syndrome  = out_syn_q;
    assign out_valid     = out_valid_q;
    assign corrected_cnt = corr_q;
    assign frame_err_cnt = ferr_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Bench for hamming74_serial_rx: directed link scenarios plus randomized single-error frames
// checked against a nearest-codeword reference decoder.
module tb_hamming74_serial_rx;

    localparam int CPB   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rx = 1'b1;
    logic             out_ready = 1'b1;
    logic [3:0]       out_data;
    logic [2:0]       out_syndrome;
    logic             out_valid;
    logic [CNT_W-1:0] corrected_cnt;
    logic [CNT_W-1:0] frame_err_cnt;
    logic [CNT_W-1:0] overrun_cnt;

    int checks = 0;
    int errors = 0;
    int exp_corr = 0;

    hamming74_serial_rx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .corrected_cnt(corrected_cnt),
        .frame_err_cnt(frame_err_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: Hamming positions 1..7 hold p1,p2,d1,p4,d2,d3,d4
    function automatic logic [6:0] encode(input logic [3:0] n);
        logic d1, d2, d3, d4;
        d1 = n[0]; d2 = n[1]; d3 = n[2]; d4 = n[3];
        return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
    endfunction

    // Decode by searching all 16 codewords for one within distance 1
    task automatic ref_decode(input logic [6:0] cw, output logic [3:0] nib, output logic [2:0] pos);
        nib = 4'd0;
        pos = 3'd0;
        for (int n = 0; n < 16; n++) begin
            logic [6:0] diff;
            diff = encode(4'(n)) ^ cw;
            if ($countones(diff) <= 1) begin
                nib = 4'(n);
                for (int b = 0; b < 7; b++) begin
                    if (diff[b]) pos = 3'(b + 1);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [6:0] cw, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 7; i++) begin
            rx = cw[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'd0 || out_syndrome !== 3'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h syn=%0d, required 0/0/0", out_valid, out_data, out_syndrome);
        end
        checks++;
        if (corrected_cnt !== 0 || frame_err_cnt !== 0 || overrun_cnt !== 0) begin
            errors++;
            $display("FAIL reset_cnt: corr=%0d ferr=%0d ovr=%0d, required 0/0/0", corrected_cnt, frame_err_cnt, overrun_cnt);
        end
        idle_bits(2);
    endtask

    task automatic test_clean();
        bit ok;
        out_ready = 1'b1;
        send_frame(7'h55, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clean_timeout: out_valid never rose, required 1");
        end else begin
            checks++;
            if (out_data !== 4'hB || out_syndrome !== 3'd0) begin
                errors++;
                $display("FAIL clean_word: data=%h syn=%0d, required b/0", out_data, out_syndrome);
            end
        end
        tick();
        checks++;
        if (corrected_cnt !== 0 || frame_err_cnt !== 0 || overrun_cnt !== 0) begin
            errors++;
            $display("FAIL clean_cnt: corr=%0d ferr=%0d ovr=%0d, required 0/0/0", corrected_cnt, frame_err_cnt, overrun_cnt);
        end
        idle_bits(2);
    endtask

    task automatic test_corrected();
        bit ok;
        send_frame(7'h45, 1'b1);
        wait_valid(ok);
        exp_corr++;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL corr_timeout: out_valid never rose, required 1");
        end else if (out_data !== 4'hB || out_syndrome !== 3'd5) begin
            errors++;
            $display("FAIL corr_word: data=%h syn=%0d, required b/5", out_data, out_syndrome);
        end
        tick();
        checks++;
        if (corrected_cnt !== CNT_W'(exp_corr)) begin
            errors++;
            $display("FAIL corr_cnt: got %0d, required %0d", corrected_cnt, exp_corr);
        end
        idle_bits(2);
    endtask

    task automatic test_frame_err();
        bit seen;
        bit ok;
        seen = 1'b0;
        send_frame(7'h55, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL ferr_no_valid: out_valid rose after bad stop bit, required none");
        end
        checks++;
        if (frame_err_cnt !== 1 || corrected_cnt !== CNT_W'(exp_corr)) begin
            errors++;
            $display("FAIL ferr_cnt: ferr=%0d corr=%0d, required 1/%0d", frame_err_cnt, corrected_cnt, exp_corr);
        end
        send_frame(7'h55, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== 4'hB || out_syndrome !== 3'd0) begin
            errors++;
            $display("FAIL ferr_recover: ok=%b data=%h syn=%0d, required 1/b/0", ok, out_data, out_syndrome);
        end
        idle_bits(2);
    endtask

    task automatic test_overrun();
        bit ok;
        out_ready = 1'b0;
        send_frame(7'h55, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovr_first: out_valid never rose, required 1");
        end
        idle_bits(2);
        send_frame(7'h00, 1'b1);
        idle_bits(3);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hB || out_syndrome !== 3'd0) begin
            errors++;
            $display("FAIL ovr_held: valid=%b data=%h syn=%0d, required 1/b/0", out_valid, out_data, out_syndrome);
        end
        checks++;
        if (overrun_cnt !== 1) begin
            errors++;
            $display("FAIL ovr_cnt: got %0d, required 1", overrun_cnt);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_accept: out_valid=%b after accept, required 0", out_valid);
        end
        idle_bits(2);
    endtask

    task automatic test_glitch();
        bit seen;
        seen = 1'b0;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || frame_err_cnt !== 1 || overrun_cnt !== 1 || corrected_cnt !== CNT_W'(exp_corr)) begin
            errors++;
            $display("FAIL glitch: valid_seen=%b ferr=%0d ovr=%0d corr=%0d, required 0/1/1/%0d",
                     seen, frame_err_cnt, overrun_cnt, corrected_cnt, exp_corr);
        end
        idle_bits(1);
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0] nib, exp_nib;
        logic [2:0] exp_pos;
        logic [6:0] cw;
        int pos;
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            nib = 4'($urandom_range(0, 15));
            pos = int'($urandom_range(0, 7));
            cw  = encode(nib);
            if (pos != 0) begin
                cw[pos-1] = ~cw[pos-1];
                exp_corr++;
            end
            ref_decode(cw, exp_nib, exp_pos);
            send_frame(cw, 1'b1);
            wait_valid(ok);
            checks++;
            if (!ok || out_data !== exp_nib || out_syndrome !== exp_pos || exp_nib !== nib) begin
                errors++;
                $display("FAIL rand_word[%0d]: cw=%h ok=%b data=%h syn=%0d, required data=%h syn=%0d",
                         k, cw, ok, out_data, out_syndrome, exp_nib, exp_pos);
            end
            idle_bits(2);
        end
        checks++;
        if (corrected_cnt !== CNT_W'(exp_corr)) begin
            errors++;
            $display("FAIL rand_corr_cnt: got %0d, required %0d", corrected_cnt, exp_corr);
        end
    endtask

    task automatic test_rst_mid_frame();
        bit ok;
        bit seen;
        send_frame(7'h55, 1'b1);
        wait_valid(ok);
        idle_bits(2);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (CPB) tick();
        end
        rx = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'd0 || out_syndrome !== 3'd0 ||
            corrected_cnt !== 0 || frame_err_cnt !== 0 || overrun_cnt !== 0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b data=%h syn=%0d corr=%0d ferr=%0d ovr=%0d, required all 0",
                     out_valid, out_data, out_syndrome, corrected_cnt, frame_err_cnt, overrun_cnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 * CPB; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_abort: aborted frame produced out_valid, required none");
        end
        send_frame(7'h00, 1'b1);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== 4'h0 || out_syndrome !== 3'd0) begin
            errors++;
            $display("FAIL rst_next: ok=%b data=%h syn=%0d, required 1/0/0", ok, out_data, out_syndrome);
        end
        idle_bits(2);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_corrected();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_random();
        test_rst_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
